// File: rtl/led_entry_pkg.sv
// Shared types, constants and nibble helpers for the LED nibble entry block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_entry_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } entry_state_t;

    localparam int NIBBLES        = 8;
    localparam int DEBOUNCE_12MHZ = 120_000;      // 10 ms at 12 MHz
    localparam int TIMEOUT_12MHZ  = 120_000_000;  // 10 s at 12 MHz

    // Bit offset of a nibble; position 0 is the most significant nibble.
    function automatic logic [4:0] nibble_lsb(input logic [2:0] sel);
        return {3'(NIBBLES - 1) - sel, 2'b00};
    endfunction

    function automatic logic [3:0] nibble_of(input logic [31:0] w, input logic [2:0] sel);
        return w[nibble_lsb(sel) +: 4];
    endfunction

    // Increment one nibble modulo 16, leaving the rest of the word alone.
    function automatic logic [31:0] inc_nibble(input logic [31:0] w, input logic [2:0] sel);
        logic [31:0] r;
        r = w;
        r[nibble_lsb(sel) +: 4] = nibble_of(w, sel) + 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronise, debounce and edge-detect one raw push-button.
// Latency: raw rising edge to press pulse is 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press is a one-cycle pulse that is never repeated while held.
// Ports: clk, rst_n (async active-low), btn_raw (async input),
//        level (debounced level), press (one-cycle pulse on debounced rise).
module button_debounce
    import led_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_12MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Count consecutive disagreeing cycles; the last one flips the level.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_nibble_entry.sv
// Two-button entry of a 32-bit value, one nibble at a time, MSB nibble first.
// Latency: button press to state/leds update 1 cycle; commit strobes value_valid as edit_active falls.
// Backpressure: none; presses are acted on immediately, an idle edit aborts after TIMEOUT_CYCLES.
// Ports: clk, rst_n, btn_inc/btn_next (raw buttons), leds (edited nibble),
//        nibble_sel (edit position), edit_active, value (committed), value_valid (strobe).
module led_nibble_entry
    import led_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_12MHZ,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_12MHZ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_next,
    output logic [3:0]  leds,
    output logic [2:0]  nibble_sel,
    output logic        edit_active,
    output logic [31:0] value,
    output logic        value_valid
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic inc_press, next_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_inc),
        .level   (),
        .press   (inc_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_next),
        .level   (),
        .press   (next_press)
    );

    entry_state_t  state_q, state_d;
    logic [31:0]   work_q,  work_d;
    logic [31:0]   value_q, value_d;
    logic [2:0]    sel_q,   sel_d;
    logic [3:0]    leds_q,  leds_d;
    logic          edit_q,  edit_d;
    logic          vv_q,    vv_d;
    logic [TW-1:0] tmo_q,   tmo_d;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        value_d = value_q;
        sel_d   = sel_q;
        vv_d    = 1'b0;
        // Saturating idle counter; only meaningful while editing.
        tmo_d   = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (next_press) begin
                    work_d  = value_q;
                    sel_d   = 3'd0;
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                    // Abandon the edit: no commit, work thrown away.
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    work_d  = '0;
                    tmo_d   = '0;
                end else if (next_press) begin
                    // next wins over a coincident inc
                    tmo_d = '0;
                    if (sel_q == 3'(NIBBLES - 1)) begin
                        value_d = work_q;
                        vv_d    = 1'b1;
                        sel_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end else if (inc_press) begin
                    tmo_d  = '0;
                    work_d = inc_nibble(work_q, sel_q);
                end
            end
            default: state_d = IDLE;
        endcase

        edit_d = (state_d == EDIT);
        leds_d = edit_d ? nibble_of(work_d, sel_d) : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            value_q <= '0;
            sel_q   <= '0;
            leds_q  <= '0;
            edit_q  <= 1'b0;
            vv_q    <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            value_q <= value_d;
            sel_q   <= sel_d;
            leds_q  <= leds_d;
            edit_q  <= edit_d;
            vv_q    <= vv_d;
            tmo_q   <= tmo_d;
        end
    end

    assign leds        = leds_q;
    assign nibble_sel  = sel_q;
    assign edit_active = edit_q;
    assign value       = value_q;
    assign value_valid = vv_q;

endmodule

// File: tb/tb_led_nibble_entry.sv
// Self-checking bench for led_nibble_entry with short debounce/timeout settings.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); committed values are matched against a queue of expectations.
module tb_led_nibble_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_next = 1'b0;
    logic [3:0]  leds;
    logic [2:0]  nibble_sel;
    logic        edit_active;
    logic [31:0] value;
    logic        value_valid;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          vv_cnt = 0;
    logic        vv_prev = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    led_nibble_entry #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_inc     (btn_inc),
        .btn_next    (btn_next),
        .leds        (leds),
        .nibble_sel  (nibble_sel),
        .edit_active (edit_active),
        .value       (value),
        .value_valid (value_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (value_valid === 1'b1) begin
            vv_cnt++;
            chk("vv_single_cycle", {31'b0, vv_prev}, 32'd0);
            chk("sb_has_expect", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("commit_value", value, exp_q.pop_front());
        end
        vv_prev = value_valid;
    end

    // Raw high 6 cycles then low 7: one debounced press, level back low at the end.
    task automatic press(input logic i, input logic n);
        btn_inc  = i;
        btn_next = n;
        repeat (6) @(negedge clk);
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic incs(input int n);
        for (int j = 0; j < n; j++) press(1'b1, 1'b0);
    endtask

    initial begin
        int t;
        int vv_before;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_leds", {28'b0, leds}, 32'd0);
        chk("rst_sel", {29'b0, nibble_sel}, 32'd0);
        chk("rst_edit", {31'b0, edit_active}, 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_vv", {31'b0, value_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Build work = 0xABCD0000, then reset mid-edit
        press(1'b0, 1'b1);
        chk("enter_edit", {31'b0, edit_active}, 32'd1);
        incs(10); press(1'b0, 1'b1);
        incs(11); press(1'b0, 1'b1);
        incs(12); press(1'b0, 1'b1);
        incs(13);
        chk("pre_rst_leds", {28'b0, leds}, 32'hD);
        chk("pre_rst_sel", {29'b0, nibble_sel}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_leds", {28'b0, leds}, 32'd0);
        chk("mid_rst_sel", {29'b0, nibble_sel}, 32'd0);
        chk("mid_rst_edit", {31'b0, edit_active}, 32'd0);
        chk("mid_rst_value", value, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_value", value, 32'd0);
        chk("post_rst_edit", {31'b0, edit_active}, 32'd0);

        // Debounce: a 3-cycle glitch is rejected, a 10-cycle hold gives one increment
        press(1'b0, 1'b1);
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_rejected", {28'b0, leds}, 32'd0);
        btn_inc = 1'b1;
        repeat (6) @(negedge clk);
        chk("deb_not_early", {28'b0, leds}, 32'd0);
        @(negedge clk);
        chk("deb_latency", {28'b0, leds}, 32'd1);
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        chk("deb_no_repeat", {28'b0, leds}, 32'd1);
        repeat (80) @(negedge clk);
        chk("deb_edit_timed_out", {31'b0, edit_active}, 32'd0);
        chk("deb_value_kept", value, 32'd0);

        // Full entry of 0x12345678
        press(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            incs(k + 1);
            chk("entry_leds", {28'b0, leds}, 32'(k + 1));
            if (k == 7) exp_q.push_back(32'h12345678);
            press(1'b0, 1'b1);
        end
        chk("entry_value", value, 32'h12345678);
        chk("entry_edit_low", {31'b0, edit_active}, 32'd0);
        chk("entry_strobes", vv_cnt, 32'd1);

        // Wrap and re-entry starting from the committed value
        press(1'b0, 1'b1);
        chk("reentry_leds", {28'b0, leds}, 32'd1);
        incs(16);
        chk("wrap_leds", {28'b0, leds}, 32'd1);
        incs(1);
        chk("wrap_plus_one", {28'b0, leds}, 32'd2);
        for (int k = 0; k < 7; k++) press(1'b0, 1'b1);
        exp_q.push_back(32'h22345678);
        press(1'b0, 1'b1);
        chk("wrap_value", value, 32'h22345678);

        // Timeout: two increments then idle, no commit
        vv_before = vv_cnt;
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        t = 0;
        while (leds !== 4'h4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_press_latency", t, 32'd7);
        btn_inc = 1'b0;
        t = 0;
        while (edit_active === 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_latency", t, 32'd65);
        chk("tmo_value_kept", value, 32'h22345678);
        chk("tmo_no_strobe", vv_cnt, 32'(vv_before));

        // Simultaneous presses in EDIT at position 2: next wins
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("sim_pre_leds", {28'b0, leds}, 32'd3);
        press(1'b1, 1'b1);
        chk("sim_sel", {29'b0, nibble_sel}, 32'd3);
        chk("sim_leds", {28'b0, leds}, 32'd4);
        for (int k = 0; k < 4; k++) press(1'b0, 1'b1);
        exp_q.push_back(32'h22345678);
        press(1'b0, 1'b1);
        chk("sim_commit_value", value, 32'h22345678);

        // Simultaneous presses in IDLE: enter EDIT with work = value
        press(1'b1, 1'b1);
        chk("sim_idle_edit", {31'b0, edit_active}, 32'd1);
        chk("sim_idle_sel", {29'b0, nibble_sel}, 32'd0);
        chk("sim_idle_leds", {28'b0, leds}, 32'd2);
        repeat (80) @(negedge clk);
        chk("sim_idle_timeout", {31'b0, edit_active}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);
        chk("total_strobes", vv_cnt, 32'd3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
